// File: rtl/mul_unit.sv
// Iterative shift-add 32x32 multiplier for RV32M MUL/MULH/MULHSU/MULHU (signed via magnitude + final negate).
// Latency: 32 CALC cycles then one DONE cycle with valid_o; MUL_EARLY_OUT_EN stops CALC once the multiplier is exhausted.
// Backpressure: none; start_i is ignored while busy_o is high, upstream holds the instruction until the pulse.
module mul_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  funct3_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] data_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MULH   = 2'd1;
    localparam logic [1:0] OP_MULHSU = 2'd2;

    state_t      state;
    logic [1:0]  op;
    logic [63:0] mcand;
    logic [63:0] acc;
    logic [31:0] mplier;
    logic [5:0]  count;
    logic        neg;

    logic        sign1;
    logic        sign2;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [63:0] acc_nxt;
    logic [31:0] mplier_nxt;
    logic [5:0]  count_nxt;
    logic        calc_done;
    logic [63:0] prod;

    always_comb begin
        sign1      = data1_i[31] & ((funct3_i == OP_MULH) | (funct3_i == OP_MULHSU));
        sign2      = data2_i[31] & (funct3_i == OP_MULH);
        // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
        mag1       = sign1 ? (~data1_i + 32'd1) : data1_i;
        mag2       = sign2 ? (~data2_i + 32'd1) : data2_i;
        acc_nxt    = mplier[0] ? (acc + mcand) : acc;
        mplier_nxt = mplier >> 1;
        count_nxt  = count + 6'd1;
`ifdef MUL_EARLY_OUT_EN
        calc_done  = (count_nxt == 6'd32) || (mplier_nxt == 32'd0);
`else
        calc_done  = (count_nxt == 6'd32);
`endif
        prod       = neg ? (~acc_nxt + 64'd1) : acc_nxt;
    end

    assign busy_o = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            op      <= OP_MUL;
            mcand   <= 64'd0;
            acc     <= 64'd0;
            mplier  <= 32'd0;
            count   <= 6'd0;
            neg     <= 1'b0;
            valid_o <= 1'b0;
            data_o  <= 32'd0;
        end else if (flush_i) begin
            state   <= IDLE;
            valid_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        op     <= funct3_i;
                        mcand  <= {32'd0, mag1};
                        mplier <= mag2;
                        neg    <= sign1 ^ sign2;
                        acc    <= 64'd0;
                        count  <= 6'd0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier_nxt;
                    count  <= count_nxt;
                    if (calc_done) begin
                        data_o  <= (op == OP_MUL) ? prod[31:0] : prod[63:32];
                        valid_o <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_unit.sv
// Randomized + directed bench for mul_unit against a plain 64-bit arithmetic reference model.
module tb_mul_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  funct3;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        flush;
    logic        busy;
    logic        valid;
    logic [31:0] dout;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_res = 32'd0;

    always #5 clk = ~clk;

    mul_unit dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .funct3_i (funct3),
        .data1_i  (d1),
        .data2_i  (d2),
        .flush_i  (flush),
        .busy_o   (busy),
        .valid_o  (valid),
        .data_o   (dout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (op == 2'd1 || op == 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (op == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // Number of cycles spent in CALC for this multiplier operand.
    function automatic int calc_cycles(input logic [1:0] op, input logic [31:0] b);
`ifdef MUL_EARLY_OUT_EN
        logic [31:0] m;
        int          n;
        m = (op == 2'd1 && b[31]) ? (32'd0 - b) : b;
        n = 1;
        for (int i = 0; i < 32; i++)
            if (m[i]) n = i + 1;
        return n;
`else
        return 32;
`endif
    endfunction

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold);
        logic [31:0] exp_d;
        int          exp_n;
        int          np;
        int          vc;
        bit          busy_ok;
        logic [31:0] got;
        exp_d   = ref_mul(op, a, b);
        exp_n   = calc_cycles(op, b) + 1;
        np      = 0;
        vc      = 0;
        busy_ok = 1'b1;
        got     = 32'd0;
        start   = 1'b1;
        funct3  = op;
        d1      = a;
        d2      = b;
        chk("busy_in_accept_cycle", {63'd0, busy}, 64'd0);
        step();
        if (hold) begin
            d1     = $urandom;
            d2     = $urandom;
            funct3 = 2'($urandom);
        end else begin
            start = 1'b0;
        end
        for (int c = 1; c <= exp_n + 1; c++) begin
            if (c <= exp_n && busy !== 1'b1) busy_ok = 1'b0;
            if (valid === 1'b1) begin
                np++;
                if (vc == 0) begin
                    vc  = c;
                    got = dout;
                end
            end
            if (c <= exp_n) begin
                if (c == exp_n) start = 1'b0;
                step();
            end
        end
        chk("valid_cycle", 64'(vc), 64'(exp_n));
        chk("valid_pulses", 64'(np), 64'd1);
        chk("result", {32'd0, got}, {32'd0, exp_d});
        chk("busy_during_op", {63'd0, busy_ok}, 64'd1);
        chk("busy_after_done", {63'd0, busy}, 64'd0);
        chk("data_hold", {32'd0, dout}, {32'd0, exp_d});
        last_res = exp_d;
    endtask

    task automatic do_abort(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int at, input bit use_rst);
        int np;
        np     = 0;
        start  = 1'b1;
        funct3 = op;
        d1     = a;
        d2     = b;
        step();
        start  = 1'b0;
        for (int c = 1; c < at; c++) begin
            if (valid === 1'b1) np++;
            step();
        end
        if (valid === 1'b1) np++;
        if (use_rst) rst = 1'b1;
        else flush = 1'b1;
        step();
        rst   = 1'b0;
        flush = 1'b0;
        if (use_rst) last_res = 32'd0;
        chk(use_rst ? "rst_busy" : "flush_busy", {63'd0, busy}, 64'd0);
        chk(use_rst ? "rst_valid" : "flush_valid", {63'd0, valid}, 64'd0);
        chk(use_rst ? "rst_data" : "flush_data", {32'd0, dout}, {32'd0, last_res});
        for (int c = 0; c < 40; c++) begin
            if (valid === 1'b1) np++;
            step();
        end
        chk(use_rst ? "rst_no_pulse" : "flush_no_pulse", 64'(np), 64'd0);
        chk(use_rst ? "rst_data_later" : "flush_data_later", {32'd0, dout}, {32'd0, last_res});
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 2'd0;
        d1     = 32'd0;
        d2     = 32'd0;
        step();
        step();
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_valid", {63'd0, valid}, 64'd0);
        chk("reset_data", {32'd0, dout}, 64'd0);
        rst = 1'b0;
        step();

        do_op(2'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
        do_op(2'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        do_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(2'd2, 32'd2, 32'h8000_0000, 1'b0);
        do_op(2'd0, 32'd5, 32'd3, 1'b0);
        do_op(2'd0, $urandom, 32'd0, 1'b0);
        do_op(2'd3, $urandom, 32'h8000_0000, 1'b1);
        do_op(2'd1, $urandom, $urandom, 1'b0);

        do_abort(2'd3, 32'h0001_2345, 32'h8000_0001, 10, 1'b0);
        do_abort(2'd3, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 20, 1'b1);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] b;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) b = -b;
            do_op(2'($urandom), $urandom, b, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
